// File: rtl/rv32i_types.sv
// Shared RV32I fetch types: machine word, BHT counter and reset constants.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [1:0]  bht_ctr_t;

  localparam bht_ctr_t  BHT_WEAK_NT = 2'b01;
  localparam rv32i_word PC_RESET    = 32'h0000_0060;

  // 2-bit saturating counter step: taken counts up to 11, not-taken down to 00
  function automatic bht_ctr_t bht_sat_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Bimodal branch history table of 2-bit saturating counters, flop-based.
// Latency: read is combinational; an update becomes visible the cycle after it is applied.
// Backpressure: none; the caller gates upd_en (stall, reset) before it reaches this table.
module bht_array
  import rv32i_types::*;
#(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t ctr_d [DEPTH];

  // Read port sees the registered value, so a same-cycle update is not bypassed
  always_comb begin
    rd_ctr = ctr_q[rd_idx];
  end

  // Next counter state: only the addressed entry moves, and only when enabled
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      ctr_d[upd_idx] = bht_sat_next(ctr_q[upd_idx], upd_taken);
    end
  end

  // Counter storage; reset clears the whole table to weakly not-taken in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_WEAK_NT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch next-PC generator: BTB + bimodal BHT prediction, EX mispredict redirect and BTB training.
// Latency: pc is registered (one cycle per step); prediction, flush and BTB write are combinational.
// Backpressure: stall freezes pc, BHT training, flush and BTB write; EX holds its resolution until stall drops.
module fetch_pc_predictor
  import rv32i_types::*;
#(
  parameter int        BHT_IDX_W = 7,
  parameter rv32i_word RESET_PC  = PC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        btb_hit,
  input  logic        btb_uncond,
  input  logic [31:0] btb_next_pc,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic        btb_write,
  output logic [31:0] btb_write_pc,
  output logic [31:0] btb_write_next_pc,
  output logic        btb_is_jal
);

  rv32i_word pc_q;
  rv32i_word pc_d;
  bht_ctr_t  bht_rd_ctr;
  logic      res;
  logic      tgt_diff;
  logic      mis;

  // Counters are indexed by the word-aligned PC bits, matching the BTB index
  bht_array #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc_q[BHT_IDX_W+1:2]),
    .rd_ctr    (bht_rd_ctr),
    .upd_en    (res & ex_is_branch),
    .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
    .upd_taken (ex_taken)
  );

  // Resolution qualification, mispredict detection and BTB training request
  always_comb begin
    res               = ex_valid & (ex_is_branch | ex_is_jal) & ~stall & ~rst;
    tgt_diff          = (ex_target != ex_pred_target);
    mis               = res & ((ex_taken != ex_pred_taken) | (ex_taken & tgt_diff));
    flush             = mis;
    btb_write         = res & ex_taken & (~ex_pred_taken | tgt_diff);
    btb_write_pc      = ex_pc;
    btb_write_next_pc = ex_target;
    btb_is_jal        = ex_is_jal;
    pred_taken        = ~rst & btb_hit & (btb_uncond | (bht_rd_ctr >= 2'b10));
    pred_target       = btb_next_pc;
    pc                = pc_q;
  end

  // Next fetch PC: stall holds, mispredict redirects, then prediction, then sequential
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall) begin
      pc_d = pc_q;
    end else if (mis) begin
      pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
    end else if (pred_taken) begin
      pc_d = btb_next_pc;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed self-checking bench for fetch_pc_predictor.
// Inputs are driven 1ns after the rising edge; outputs are sampled before the next edge.
// Every expected value below is a hand-computed constant.
module tb_fetch_pc_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        btb_hit;
  logic        btb_uncond;
  logic [31:0] btb_next_pc;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic        btb_write;
  logic [31:0] btb_write_pc;
  logic [31:0] btb_write_next_pc;
  logic        btb_is_jal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .btb_hit           (btb_hit),
    .btb_uncond        (btb_uncond),
    .btb_next_pc       (btb_next_pc),
    .pc                (pc),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .ex_valid          (ex_valid),
    .ex_is_branch      (ex_is_branch),
    .ex_is_jal         (ex_is_jal),
    .ex_pc             (ex_pc),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pred_target    (ex_pred_target),
    .flush             (flush),
    .btb_write         (btb_write),
    .btb_write_pc      (btb_write_pc),
    .btb_write_next_pc (btb_write_next_pc),
    .btb_is_jal        (btb_is_jal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock, land 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_is_jal      = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  task automatic ex_set(input logic br, input logic jal, input logic [31:0] epc,
                        input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = br;
    ex_is_jal      = jal;
    ex_pc          = epc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  // Steer fetch with an unpredicted JAL at 0x40 (JALs leave the BHT alone)
  task automatic redirect(input logic [31:0] tgt);
    btb_hit = 1'b0;
    ex_set(1'b0, 1'b1, 32'h40, 1'b1, tgt, 1'b0, 32'h0);
    tick();
    ex_clear();
    chk("redirect_pc", pc, tgt);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    btb_hit     = 1'b1;
    btb_uncond  = 1'b1;
    btb_next_pc = 32'h0000_0500;
    ex_clear();
    // a mispredicting resolution present during reset must be ignored
    ex_set(1'b1, 1'b0, 32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_btb_write", {31'b0, btb_write}, 32'd0);
    chk("rst_pc", pc, 32'h60);

    // 1: sequential fetch after reset
    rst     = 1'b0;
    btb_hit = 1'b0;
    ex_clear();
    #1;
    chk("seq_flush", {31'b0, flush}, 32'd0);
    chk("seq_btb_write", {31'b0, btb_write}, 32'd0);
    tick();
    chk("seq_pc1", pc, 32'h64);
    tick();
    chk("seq_pc2", pc, 32'h68);
    btb_hit    = 1'b1;
    btb_uncond = 1'b0;
    #1;
    chk("init_ctr_nt", {31'b0, pred_taken}, 32'd0);
    btb_hit = 1'b0;

    // 2: unpredicted JAL
    ex_set(1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    chk("jal_flush", {31'b0, flush}, 32'd1);
    chk("jal_btb_write", {31'b0, btb_write}, 32'd1);
    chk("jal_wr_pc", btb_write_pc, 32'h80);
    chk("jal_wr_next", btb_write_next_pc, 32'h200);
    chk("jal_is_jal", {31'b0, btb_is_jal}, 32'd1);
    tick();
    ex_clear();
    chk("jal_pc", pc, 32'h200);

    // 3: BTB hit on an unconditional entry
    redirect(32'h80);
    btb_hit     = 1'b1;
    btb_uncond  = 1'b1;
    btb_next_pc = 32'h200;
    #1;
    chk("hit_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("hit_pred_target", pred_target, 32'h200);
    tick();
    chk("hit_pc", pc, 32'h200);
    btb_hit    = 1'b0;
    btb_uncond = 1'b0;

    // 4: train branch at 0x100 taken three times (01->10->11->11), no mispredicts
    for (int i = 0; i < 3; i++) begin
      ex_set(1'b1, 1'b0, 32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
      #1;
      chk("train_flush", {31'b0, flush}, 32'd0);
      chk("train_btb_write", {31'b0, btb_write}, 32'd0);
      tick();
    end
    ex_clear();
    redirect(32'h100);
    btb_hit     = 1'b1;
    btb_next_pc = 32'h300;
    #1;
    chk("ctr11_taken", {31'b0, pred_taken}, 32'd1);
    // correctly predicted not-taken in the same cycle: lookup still sees 11
    ex_set(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("nt1_same_cycle", {31'b0, pred_taken}, 32'd1);
    chk("nt1_flush", {31'b0, flush}, 32'd0);
    tick();
    ex_clear();
    chk("pred_pc", pc, 32'h300);
    redirect(32'h100);
    btb_hit = 1'b1;
    #1;
    chk("ctr10_taken", {31'b0, pred_taken}, 32'd1);
    ex_set(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    ex_clear();
    redirect(32'h100);
    btb_hit = 1'b1;
    #1;
    chk("ctr01_not_taken", {31'b0, pred_taken}, 32'd0);
    btb_hit = 1'b0;

    // 5: predicted taken but actually not taken (counter 01->00)
    ex_set(1'b1, 1'b0, 32'h100, 1'b0, 32'h300, 1'b1, 32'h300);
    #1;
    chk("wt_flush", {31'b0, flush}, 32'd1);
    chk("wt_btb_write", {31'b0, btb_write}, 32'd0);
    tick();
    ex_clear();
    chk("wt_pc", pc, 32'h104);

    // 6: mispredict (counter 00 -> 01) held under a 3-cycle stall
    ex_set(1'b1, 1'b0, 32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_flush", {31'b0, flush}, 32'd0);
      chk("stall_btb_write", {31'b0, btb_write}, 32'd0);
      tick();
      chk("stall_pc", pc, 32'h104);
    end
    stall = 1'b0;
    #1;
    chk("unstall_flush", {31'b0, flush}, 32'd1);
    chk("unstall_btb_write", {31'b0, btb_write}, 32'd1);
    tick();
    chk("unstall_pc", pc, 32'h180);
    ex_clear();
    // one increment from 00 gives 01 (not taken); stalled updates would give 11
    redirect(32'h100);
    btb_hit = 1'b1;
    #1;
    chk("stall_ctr_once", {31'b0, pred_taken}, 32'd0);
    // one more taken must flip it to 10, proving it sat at 01 rather than 00
    ex_set(1'b1, 1'b0, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180);
    btb_hit = 1'b0;
    tick();
    ex_clear();
    redirect(32'h100);
    btb_hit     = 1'b1;
    btb_next_pc = 32'h180;
    #1;
    chk("stall_ctr_10", {31'b0, pred_taken}, 32'd1);
    btb_hit = 1'b0;

    // PC wrap
    redirect(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
Fetch-stage next-PC generator that drives the BTB lookup PC and owns a bimodal branch history table (BHT) of 2-bit saturating counters. It combines the BTB hit, uncond and next_pc outputs with the BHT to choose the next fetch PC. It consumes branch/JAL resolution from EX to raise flush/redirect, train the counters and issue BTB writes.

Parameters:
BHT_IDX_W, 7, BHT index width; 2^7 = 128 entries, indexed by pc[BHT_IDX_W+1:2], which aligns with the BTB index pc[8:2].
RESET_PC, 32'h00000060, fetch PC after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  1  freezes all state and side effects
btb_hit  in  1  BTB hit for current pc
btb_uncond  in  1  BTB entry is a JAL
btb_next_pc  in  32  BTB predicted target
pc  out  32  current fetch PC; goes to BTB and I-cache
pred_taken  out  1  prediction for pc; travels down the pipeline
pred_target  out  32  predicted target (equals btb_next_pc)
ex_valid  in  1  EX holds a valid control-flow resolution
ex_is_branch  in  1  conditional branch
ex_is_jal  in  1  JAL
ex_pc  in  32  PC of the resolving instruction
ex_taken  in  1  actual outcome (1 for JAL)
ex_target  in  32  actual target
ex_pred_taken  in  1  prediction carried with the instruction
ex_pred_target  in  32  predicted target carried with the instruction
flush  out  1  squash younger instructions this cycle
btb_write  out  1  BTB write enable
btb_write_pc  out  32  BTB write key (= ex_pc)
btb_write_next_pc  out  32  BTB write data (= ex_target)
btb_is_jal  out  1  BTB uncond bit (= ex_is_jal)

Behaviour:
- Reset: rst is synchronous and active-high, on clk.
  - pc <= RESET_PC.
  - All BHT counters <= 2'b01 (weakly not-taken). The BHT is flops, cleared in one cycle.
  - While rst=1: pred_taken, flush and btb_write are forced to 0.
  - Reset mid-operation discards any in-flight resolution.
- Resolution qualifier: res = ex_valid & (ex_is_branch | ex_is_jal) & ~stall.
- Mispredict: mis = res & ((ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target))).
- flush = mis. It is combinational, in the same cycle as the EX inputs.
- Prediction (combinational from pc and BTB outputs):
  - pred_taken = btb_hit & (btb_uncond | bht[idx(pc)][1]).
  - pred_target = btb_next_pc.
- Next PC, priority order:
  1. rst -> RESET_PC.
  2. stall -> hold.
  3. mis -> (ex_taken ? ex_target : ex_pc + 4).
  4. pred_taken -> btb_next_pc.
  5. Otherwise pc + 4.
- PC arithmetic is modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
- BHT update:
  - Occurs on res & ex_is_branch, at idx(ex_pc).
  - Taken: saturating increment, capped at 11. Not-taken: saturating decrement, floored at 00.
  - JAL resolutions do not touch the BHT.
- Same-cycle BHT read/write to the same index: the lookup sees the pre-update value; the new value is visible next cycle.
- BTB write:
  - btb_write = res & ex_taken & (~ex_pred_taken | (ex_target != ex_pred_target)). Combinational.
  - The BTB captures the write on the same clk edge.
  - While btb_write=1 the BTB reports hit=0 for that cycle, so fetch falls to pc+4 unless mis redirects.
- Stall:
  - No pc change, no BHT update, no BTB write, no flush.
  - EX holds ex_* stable across the stall. The resolution acts exactly once, in the first cycle with stall=0.
- No registered outputs other than pc; all other outputs are combinational.

Decomposition:
- rv32i_types package:
  - rv32i_word (already present).
  - New typedef bht_ctr_t (logic [1:0]).
  - Constants BHT_WEAK_NT = 2'b01 and PC_RESET = 32'h60.
- One sub-module, bht_array: counter storage, synchronous reset to BHT_WEAK_NT, one combinational read port, one saturating update port.
- The top level holds the pc register, mispredict detection and the next-PC mux.

Test Plan:
1. Reset, then btb_hit=0 -> pc sequence 0x60, 0x64, 0x68; flush=0; btb_write=0; a lookup at any index shows counter 01.
2. Unpredicted JAL: res with ex_is_jal, ex_pc=0x80, ex_target=0x200, ex_pred_taken=0 -> flush=1; btb_write=1 (pc 0x80, next 0x200, is_jal=1); next pc=0x200; BHT unchanged.
3. BTB hit: pc=0x80, btb_hit=1, uncond=1, next 0x200 -> pred_taken=1, pred_target=0x200, next pc=0x200.
4. Counter training, branch at 0x100:
   - 3 taken resolutions -> counter 01->10->11->11.
   - Lookup with btb_hit=1, uncond=0 -> pred_taken=1.
   - 1 not-taken (11->10) -> still taken; 2nd not-taken (10->01) -> pred_taken=0.
5. Wrong taken: ex_pc=0x100, ex_pred_taken=1, ex_pred_target=0x300, ex_taken=0 -> flush=1, next pc=0x104, btb_write=0.
6. Stall and wrap:
   - Mispredict held with stall=1 for 3 cycles -> pc frozen, flush=0, counter unchanged.
   - stall drops -> exactly one flush and one update.
   - Separately, pc=0xFFFFFFFC with no hit -> pc=0x00000000.
